io_output_fifo: RTL and testbench
=================================

// Module: io_output_fifo
// PURPOSE
//  Buffers the CPU result bus on its way to the host/IO side. Samples writeData
//  (CPU out) on every cycle where writeValid (CPU outFlagIOE) is high.
//  Drains in order through a valid/ready read port.
//  almostFull gives the CPU/host an early stall hint; overflow is a sticky error flag.
// PARAMETERS
//  WIDTH     36  data word width; equals the CPU datapath width
//  DEPTH     8   number of entries; must be a power of 2, >= 4
//  PTRWIDTH  3   log2(DEPTH); pointer width
// PORTS
//  clock          in   1           system clock, rising edge
//  reset          in   1           asynchronous, active-high
//  writeValid     in   1           capture request (from CPU outFlagIOE)
//  writeData      in   WIDTH       word to capture (from CPU out)
//  readReady      in   1           consumer accepts readData this cycle
//  readValid      out  1           readData holds the oldest unread word
//  readData       out  WIDTH       head-of-queue word; 0 when readValid=0
//  count          out  PTRWIDTH+1  entries stored, 0..DEPTH
//  almostFull     out  1           count >= DEPTH-2
//  overflow       out  1           sticky: a write was dropped
//  clearOverflow  in   1           synchronous clear of overflow
// BEHAVIOUR
//  - Reset (async, active-high) clears wrPtr, rdPtr, count and overflow to 0.
//    Outputs then read: readValid=0, readData=0, almostFull=0.
//    Storage array is not reset.
//  - Write accept: writeValid && (count<DEPTH || readFire), where readFire = readValid && readReady.
//    On accept: mem[wrPtr]<=writeData and wrPtr<=wrPtr+1, mod DEPTH (natural wrap).
//  - Read: on readFire, rdPtr<=rdPtr+1 (mod DEPTH). readData is combinational mem[rdPtr] gated by readValid.
//  - readValid = (count!=0). There is no write-to-read bypass.
//    A word written into an empty FIFO appears on readValid one cycle after the write edge.
//  - count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
//  - Full (count==DEPTH):
//    - writeValid with readFire: both happen, count stays DEPTH, no overflow.
//    - writeValid without readFire: the word is dropped, overflow<=1, pointers unchanged.
//  - Empty (count==0): readReady is ignored; rdPtr and count are unchanged.
//  - overflow is cleared by clearOverflow on the next edge.
//    If a drop and a clearOverflow occur in the same cycle, the set wins (overflow=1).
//  - Ordering: words leave in exactly the order accepted, across pointer wrap.
//  - readValid/readData handshake: while readValid=1 and readReady=0, readData is held stable.
//    This holds even if writes occur in the same cycle.
//  - almostFull is derived combinationally from the registered count; no extra latency.
//  - Reset mid-operation: all contents are discarded immediately (readValid drops asynchronously).
//    The first write after reset deassertion lands in entry 0.
//  - writeData and writeValid are sampled only at rising clock edges.
//    A single-cycle outFlagIOE pulse yields exactly one entry.
// TESTING
//  T1 reset, write 36'h0_0000_0005 once, readReady=0
//     -> count=1; readValid=1 on the next cycle; readData=5; held stable for 3 idle cycles.
//  T2 DEPTH=8: write 1..8 back-to-back, readReady=0
//     -> count=8; almostFull=1 from count=6 onward; overflow=0.
//     A 9th write (value 9) -> overflow=1, count=8.
//  T3 full FIFO, write 9 and readReady=1 in the same cycle
//     -> head 1 is popped, 9 is stored, count=8, overflow=0.
//     Drain order must then be 2,3,...,8,9.
//  T4 write 12 words while reading continuously (readReady=1)
//     -> sequence intact across wrap; count never exceeds 2; readData=0 whenever empty.
//  T5 overflow=1, then clearOverflow together with a dropped write
//     -> overflow stays 1. clearOverflow alone on the next cycle -> overflow=0.
//  T6 count=5, assert reset for half a cycle between edges
//     -> count=0, readValid=0 immediately. Next write of 36'hA lands and reads back as A.

Source files
------------

// File: rtl/io_output_fifo.sv
// Output FIFO between the CPU result bus and the host/IO side.
// In-order drain on a valid/ready port, with an almost-full hint and a sticky overflow flag.
module io_output_fifo #(
  parameter int WIDTH    = 36,
  parameter int DEPTH    = 8,
  parameter int PTRWIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                writeValid,
  input  logic [WIDTH-1:0]    writeData,
  input  logic                readReady,
  output logic                readValid,
  output logic [WIDTH-1:0]    readData,
  output logic [PTRWIDTH:0]   count,
  output logic                almostFull,
  output logic                overflow,
  input  logic                clearOverflow
);

  localparam logic [PTRWIDTH:0] DEPTH_C = (PTRWIDTH+1)'(DEPTH);
  localparam logic [PTRWIDTH:0] AFULL_C = (PTRWIDTH+1)'(DEPTH - 2);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRWIDTH:0]   count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                read_fire_s;
  logic                write_accept_s;
  logic                drop_s;

  assign readValid      = (count_q != {(PTRWIDTH+1){1'b0}});
  assign read_fire_s    = readValid && readReady;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign write_accept_s = writeValid && ((count_q < DEPTH_C) || read_fire_s);
  assign drop_s         = writeValid && !write_accept_s;

  assign readData   = readValid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
  assign count      = count_q;
  assign almostFull = (count_q >= AFULL_C);
  assign overflow   = overflow_q;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (write_accept_s) begin
      wr_ptr_d = wr_ptr_q + {{(PTRWIDTH-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (read_fire_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTRWIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({write_accept_s, read_fire_s})
      2'b10:   count_d = count_q + {{PTRWIDTH{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PTRWIDTH{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear must leave the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clearOverflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= {PTRWIDTH{1'b0}};
      rd_ptr_q   <= {PTRWIDTH{1'b0}};
      count_q    <= {(PTRWIDTH+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are left as-is across reset.
  always_ff @(posedge clock) begin
    if (write_accept_s) begin
      mem_q[wr_ptr_q] <= writeData;
    end
  end

endmodule

// File: tb/tb_io_output_fifo.sv
// Self-checking bench for io_output_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_io_output_fifo;

  localparam int WIDTH    = 36;
  localparam int DEPTH    = 8;
  localparam int PTRWIDTH = 3;

  logic              clock;
  logic              reset;
  logic              writeValid;
  logic [WIDTH-1:0]  writeData;
  logic              readReady;
  logic              readValid;
  logic [WIDTH-1:0]  readData;
  logic [PTRWIDTH:0] count;
  logic              almostFull;
  logic              overflow;
  logic              clearOverflow;

  int tests_run = 0;
  int tests_failed = 0;
  int max_count = 0;

  logic [WIDTH-1:0] model_q [$];
  logic             model_ovf = 1'b0;

  io_output_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRWIDTH(PTRWIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .writeValid(writeValid),
    .writeData(writeData),
    .readReady(readReady),
    .readValid(readValid),
    .readData(readData),
    .count(count),
    .almostFull(almostFull),
    .overflow(overflow),
    .clearOverflow(clearOverflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_data;
    exp_data = (model_q.size() != 0) ? model_q[0] : '0;
    check({tag, ".count"},      64'(count),      64'(model_q.size()));
    check({tag, ".readValid"},  64'(readValid),  64'(model_q.size() != 0));
    check({tag, ".readData"},   64'(readData),   64'(exp_data));
    check({tag, ".almostFull"}, 64'(almostFull), 64'(model_q.size() >= DEPTH - 2));
    check({tag, ".overflow"},   64'(overflow),   64'(model_ovf));
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, check after edge.
  task automatic step(input string tag, input logic wv, input logic [WIDTH-1:0] wd,
                      input logic rr, input logic clr);
    bit fire, accept;
    @(negedge clock);
    writeValid    = wv;
    writeData     = wd;
    readReady     = rr;
    clearOverflow = clr;
    fire   = (model_q.size() != 0) && rr;
    accept = wv && ((model_q.size() < DEPTH) || fire);
    @(posedge clock);
    if (fire) void'(model_q.pop_front());
    if (accept) model_q.push_back(wd);
    if (wv && !accept) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
    #1;
    if (model_q.size() > max_count) max_count = model_q.size();
    check_all(tag);
  endtask

  // Reset pulse between clock edges; contents must vanish before the next edge.
  task automatic mid_reset(input string tag);
    @(negedge clock);
    writeValid = 1'b0;
    readReady = 1'b0;
    clearOverflow = 1'b0;
    #1 reset = 1'b1;
    #1;
    check({tag, ".count"},     64'(count),     64'd0);
    check({tag, ".readValid"}, 64'(readValid), 64'd0);
    check({tag, ".readData"},  64'(readData),  64'd0);
    check({tag, ".overflow"},  64'(overflow),  64'd0);
    #1 reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    reset = 1'b0;
    writeValid = 1'b0;
    writeData = '0;
    readReady = 1'b0;
    clearOverflow = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_all("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // T1: single write, held stable while not read
    step("t1_wr", 1'b1, 36'h0_0000_0005, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t1_hold", 1'b0, 36'h0, 1'b0, 1'b0);
      check("t1_data5", 64'(readData), 64'd5);
    end

    // T2: fill to DEPTH, then a dropped 9th write
    mid_reset("t2_rst");
    for (int i = 1; i <= DEPTH; i++) step("t2_fill", 1'b1, 36'(i), 1'b0, 1'b0);
    check("t2_full_count", 64'(count), 64'd8);
    step("t2_drop", 1'b1, 36'd9, 1'b0, 1'b0);
    check("t2_ovf", 64'(overflow), 64'd1);

    // T3: write while full and reading; then drain 2..9
    mid_reset("t3_rst");
    for (int i = 1; i <= DEPTH; i++) step("t3_fill", 1'b1, 36'(i), 1'b0, 1'b0);
    step("t3_wr_rd", 1'b1, 36'd9, 1'b1, 1'b0);
    check("t3_count", 64'(count), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd0);
    for (int i = 2; i <= 9; i++) begin
      check("t3_order", 64'(readData), 64'(i));
      step("t3_drain", 1'b0, 36'h0, 1'b1, 1'b0);
    end

    // T4: streaming through the pointer wrap
    mid_reset("t4_rst");
    max_count = 0;
    for (int i = 0; i < 12; i++) step("t4_stream", 1'b1, 36'(100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("t4_tail", 1'b0, 36'h0, 1'b1, 1'b0);
    check("t4_max_count", 64'(max_count <= 2), 64'd1);
    check("t4_empty_data", 64'(readData), 64'd0);

    // T5: drop beats clear, then clear alone
    mid_reset("t5_rst");
    for (int i = 0; i < DEPTH; i++) step("t5_fill", 1'b1, 36'(i), 1'b0, 1'b0);
    step("t5_drop", 1'b1, 36'h55, 1'b0, 1'b0);
    step("t5_drop_clr", 1'b1, 36'h66, 1'b0, 1'b1);
    check("t5_ovf_held", 64'(overflow), 64'd1);
    step("t5_clr", 1'b0, 36'h0, 1'b0, 1'b1);
    check("t5_ovf_clr", 64'(overflow), 64'd0);

    // T6: reset with five entries stored, then first write lands in entry 0
    mid_reset("t6_pre");
    for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, 36'(i + 20), 1'b0, 1'b0);
    mid_reset("t6_rst");
    step("t6_wr", 1'b1, 36'hA, 1'b0, 1'b0);
    check("t6_readA", 64'(readData), 64'hA);
    step("t6_rd", 1'b0, 36'h0, 1'b1, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd = {4'($urandom), 32'($urandom)};
      step("rand", 1'($urandom_range(0, 99) < 60), rd,
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
